// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator for a 1-bit PDM stream clocked by an asynchronous bit clock.
// Produces offset-binary 32-bit PCM samples at the selected decimation ratio.
module pdm_cic_decimator #(
  parameter int unsigned DW = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ock,
  input  logic        sdi,
  input  logic        en,
  input  logic [1:0]  dec_sel,
  output logic [31:0] dout,
  output logic        dout_vld
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t state_q, state_d;

  logic          ock_s1, ock_s2, ock_q, sdi_s1, sdi_s2;
  logic [1:0]    r_sel;
  logic [5:0]    cnt;
  logic [1:0]    pcnt;
  logic [DW-1:0] i1, i2, i3;
  logic [DW-1:0] c1, c2, y, d0, d1, d2;
  logic [3:0]    pipe, tag;

  logic          strobe_c, active_c, boundary_c;
  logic [5:0]    r_max_c;
  logic [4:0]    shift_c;
  logic [DW-1:0] x_c;
  logic [32:0]   y_ext_c, sum_c;
  logic [31:0]   dout_c;

  // Ratio-dependent terminal count and output scaling (shift = 31 - 3*log2(R))
  always_comb begin
    r_max_c = 6'd63;
    shift_c = 5'd13;
    case (r_sel)
      2'd0: begin r_max_c = 6'd15; shift_c = 5'd19; end
      2'd1: begin r_max_c = 6'd31; shift_c = 5'd16; end
      default: begin r_max_c = 6'd63; shift_c = 5'd13; end
    endcase
  end

  assign strobe_c   = ock_s2 & ~ock_q;
  assign active_c   = en && (state_q != IDLE);
  assign boundary_c = strobe_c && active_c && (cnt == r_max_c);
  assign x_c        = sdi_s2 ? DW'(1) : {DW{1'b1}};

  // Only y = +R^3 can reach 2^32 after offsetting; clamp it to full scale
  assign y_ext_c = {{(33 - DW){y[DW-1]}}, y};
  assign sum_c   = (y_ext_c << shift_c) + 33'h0_8000_0000;
  assign dout_c  = sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = PRIME;
      PRIME:   if (!en) state_d = IDLE;
               else if (boundary_c && pcnt == 2'd2) state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ock_s1 <= 1'b0; ock_s2 <= 1'b0; ock_q <= 1'b0;
      sdi_s1 <= 1'b0; sdi_s2 <= 1'b0;
      r_sel <= 2'd0; cnt <= 6'd0; pcnt <= 2'd0;
      i1 <= '0; i2 <= '0; i3 <= '0;
      c1 <= '0; c2 <= '0; y <= '0; d0 <= '0; d1 <= '0; d2 <= '0;
      pipe <= 4'd0; tag <= 4'd0;
      dout <= 32'h8000_0000;
      dout_vld <= 1'b0;
    end else begin
      state_q  <= state_d;
      ock_s1   <= ock;    ock_s2 <= ock_s1;  ock_q <= ock_s2;
      sdi_s1   <= sdi;    sdi_s2 <= sdi_s1;
      dout_vld <= 1'b0;
      if (!en) begin
        cnt <= 6'd0; pcnt <= 2'd0;
        i1 <= '0; i2 <= '0; i3 <= '0;
        c1 <= '0; c2 <= '0; y <= '0; d0 <= '0; d1 <= '0; d2 <= '0;
        pipe <= 4'd0; tag <= 4'd0;
      end else begin
        if (state_q == IDLE) r_sel <= dec_sel;
        if (strobe_c && active_c) begin
          i1  <= i1 + x_c;
          i2  <= i2 + i1;
          i3  <= i3 + i2;
          cnt <= boundary_c ? 6'd0 : cnt + 6'd1;
          if (boundary_c && state_q == PRIME) pcnt <= pcnt + 2'd1;
        end
        // Boundary flags ride alongside the comb stages; tag marks samples taken in RUN
        pipe <= {pipe[2:0], boundary_c};
        tag  <= {tag[2:0], boundary_c && state_q == RUN};
        if (pipe[0]) begin c1 <= i3 - d0; d0 <= i3; end
        if (pipe[1]) begin c2 <= c1 - d1; d1 <= c1; end
        if (pipe[2]) begin y  <= c2 - d2; d2 <= c2; end
        if (pipe[3] && tag[3]) begin
          dout     <= dout_c;
          dout_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: PDM patterns with hand-derived PCM results,
// output timing in ock rises, reset/enable aborts and dec_sel latching.
module tb_pdm_cic_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ock = 1'b0;
  logic        sdi = 1'b0;
  logic        en  = 1'b0;
  logic [1:0]  dec_sel = 2'd0;
  logic [31:0] dout;
  logic        dout_vld;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  int ph    = 0;
  logic [31:0] vals[$];
  int          stamps[$];

  pdm_cic_decimator #(.DW(20)) dut (
    .clk(clk), .rst(rst), .ock(ock), .sdi(sdi), .en(en),
    .dec_sel(dec_sel), .dout(dout), .dout_vld(dout_vld)
  );

  always #5 clk = ~clk;

  // Record every output pulse with the ock-rise count at which it appeared
  always @(negedge clk) begin
    if (dout_vld) begin
      vals.push_back(dout);
      stamps.push_back(rises);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // n ock periods; pattern bit pat[ph % plen] is presented before each rise
  task automatic run_ock(input int n, input logic [3:0] pat, input int plen);
    logic [3:0] p;
    p = pat;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sdi = p[ph % plen];
      ph++;
      repeat (4) @(posedge clk);
      #1 ock = 1'b1;
      rises++;
      repeat (8) @(posedge clk);
      #1 ock = 1'b0;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic start(input logic [1:0] sel);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dec_sel = sel;
    rises = 0;
    ph = 0;
    vals.delete();
    stamps.delete();
    en = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic fresh();
    rises = 0;
    ph = 0;
    vals.delete();
    stamps.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", dout, 32'h8000_0000);
    check("reset_vld", 32'(dout_vld), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // R=16, all ones: first pulse at 64th rise, then every 16, full scale
    start(2'd0);
    run_ock(96, 4'b0001, 1);
    check("ones16_count", 32'(vals.size()), 32'd3);
    if (vals.size() >= 2) begin
      check("ones16_first_at", 32'(stamps[0]), 32'd64);
      check("ones16_second_at", 32'(stamps[1]), 32'd80);
      check("ones16_value", vals[0], 32'hFFFF_FFFF);
    end
    @(posedge clk); #1 en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("en_low_hold", dout, 32'hFFFF_FFFF);
    check("en_low_vld", 32'(dout_vld), 32'd0);

    // R=16, all zeros -> bottom of scale
    start(2'd0);
    run_ock(80, 4'b0000, 1);
    check("zeros16_count", 32'(vals.size()), 32'd2);
    if (vals.size() > 0) check("zeros16_value", vals[vals.size()-1], 32'h0000_0000);

    // R=16, alternating 1,0 -> midscale
    start(2'd0);
    run_ock(80, 4'b0001, 2);
    if (vals.size() > 0) check("alt16_value", vals[vals.size()-1], 32'h8000_0000);
    else check("alt16_value", 32'hDEAD_BEEF, 32'h8000_0000);

    // R=32, 1,1,1,0 -> +0.5 full scale
    start(2'd1);
    run_ock(160, 4'b0111, 4);
    check("d75_count", 32'(vals.size()), 32'd2);
    if (vals.size() >= 2) begin
      check("d75_first_at", 32'(stamps[0]), 32'd128);
      check("d75_value", vals[1], 32'hC000_0000);
    end

    // R=32, 1,0,0,0 -> -0.5 full scale
    start(2'd1);
    run_ock(160, 4'b0001, 4);
    if (vals.size() > 0) check("d25_value", vals[vals.size()-1], 32'h4000_0000);
    else check("d25_value", 32'hDEAD_BEEF, 32'h4000_0000);

    // R=64, all ones; dec_sel changed mid-run must not alter the ratio
    start(2'd2);
    run_ock(320, 4'b0001, 1);
    @(posedge clk); #1 dec_sel = 2'd0;
    run_ock(64, 4'b0001, 1);
    check("r64_count", 32'(vals.size()), 32'd3);
    if (vals.size() == 3) begin
      check("r64_first_at", 32'(stamps[0]), 32'd256);
      check("r64_third_at", 32'(stamps[2]), 32'd384);
      check("r64_value", vals[2], 32'hFFFF_FFFF);
    end

    // Reset during RUN: immediate midscale, then full re-prime
    start(2'd0);
    run_ock(70, 4'b0001, 1);
    check("prerst_count", 32'(vals.size()), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_run_dout", dout, 32'h8000_0000);
    check("rst_run_vld", 32'(dout_vld), 32'd0);
    fresh();
    repeat (3) @(posedge clk);
    run_ock(80, 4'b0001, 1);
    check("postrst_count", 32'(vals.size()), 32'd2);
    if (vals.size() > 0) check("postrst_first_at", 32'(stamps[0]), 32'd64);

    // One-cycle enable drop mid-PRIME restarts priming
    start(2'd0);
    run_ock(40, 4'b0001, 1);
    check("prime_no_pulse", 32'(vals.size()), 32'd0);
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
    fresh();
    repeat (3) @(posedge clk);
    run_ock(80, 4'b0001, 1);
    check("reprime_count", 32'(vals.size()), 32'd2);
    if (vals.size() > 0) begin
      check("reprime_first_at", 32'(stamps[0]), 32'd64);
      check("reprime_value", vals[0], 32'hFFFF_FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 SHALL have parameter DW, default 20, meaning integrator/comb register width (two's complement, modulo 2^DW).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port ock, input, 1, PDM bit clock, asynchronous to clk.
REQ-005 SHALL have port sdi, input, 1, PDM data from the modulator/microphone, valid at ock rising edge.
REQ-006 SHALL have port en, input, 1, run enable.
REQ-007 SHALL have port dec_sel, input, 2, decimation ratio R: 0=16, 1=32, 2=64, 3=64.
REQ-008 SHALL have port dout, output, 32, PCM sample, unsigned offset-binary, midscale 32'h80000000.
REQ-009 SHALL have port dout_vld, output, 1, one-clk pulse when dout updates.

Function
REQ-010 SHALL pass ock and sdi through 2-flop synchronizers; an ock rise is detected from synced ock (0 then 1) and produces a one-clk strobe.
REQ-011 SHALL, on each strobe, map the synced sdi to +1 (1) or -1 (0) and feed it to 3 cascaded DW-bit integrators, all updated in the strobe cycle.
REQ-012 SHALL count strobes modulo R; the strobe carrying the R-th sample is the boundary cycle T.
REQ-013 SHALL run a 3-stage pipelined comb (differential delay 1): comb1 registered at T+1, comb2 at T+2, comb3 (y) at T+3.
REQ-014 SHALL, at T+4, load dout = (y << (31-3k)) + 2^31, where k = log2(R), and pulse dout_vld for exactly that cycle.
REQ-015 SHALL saturate dout to 32'hFFFFFFFF when y = +R^3; y = -R^3 gives 32'h00000000.
REQ-016 SHALL implement FSM IDLE, PRIME, RUN: IDLE while en=0; IDLE->PRIME on en=1; PRIME->RUN after 3 boundaries; in PRIME the comb pipeline runs, but dout and dout_vld are suppressed.
REQ-017 SHALL latch dec_sel only on the IDLE->PRIME transition; dec_sel changes while en=1 are ignored.
REQ-018 SHALL, on en=0 from any state, go to IDLE on the next clk and clear integrators, combs, strobe counter and prime counter; dout holds its last value; dout_vld=0.
REQ-019 SHALL require at least 3 clk per ock half-period; behaviour outside this is undefined.
REQ-020 SHALL, when a strobe coincides with the comb pipeline activity of T+1..T+3, update the integrators without disturbing the comb pipeline.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, set FSM=IDLE, integrators/combs/counters/synchronizers=0, dout=32'h80000000, dout_vld=0.
REQ-022 SHALL give rst priority over en and over every strobe; rst mid-PRIME/RUN aborts with no dout_vld pulse afterwards until re-prime.

Verification
REQ-023 SHALL cover: dec_sel=0, sdi constant 1, en raised -> first dout_vld 4 clk after the 64th ock rise, dout=32'hFFFFFFFF, then one pulse per 16 ock rises.
REQ-024 SHALL cover: dec_sel=0, sdi constant 0 -> dout=32'h00000000; sdi pattern 1,0 repeating -> dout=32'h80000000.
REQ-025 SHALL cover: dec_sel=1, sdi pattern 1,1,1,0 repeating -> settled dout=32'hC0000000; pattern 1,0,0,0 -> 32'h40000000.
REQ-026 SHALL cover: dec_sel=2, sdi constant 1 -> dout=32'hFFFFFFFF, with first dout_vld after 256 ock rises + 4 clk; toggling dec_sel mid-run -> ratio unchanged.
REQ-027 SHALL cover: rst=1 pulse during RUN -> next clk dout=32'h80000000, dout_vld=0; no pulse until 4 boundaries after rst release with en=1.
REQ-028 SHALL cover: en dropped for 1 clk mid-PRIME -> counters cleared and priming restarts (first dout_vld 4R ock rises + 4 clk after en returns).
